win_mac_pipe: RTL and testbench
===============================

Name: win_mac_pipe

Overview:
Parametrised streaming arithmetic block that evaluates a 3-sample window expression over consecutive valid input samples. The baseline expression is a*b+c: a is the sample two valid cycles back, b is one back, c is the current sample. This block generalises that datapath with configurable data/output width, a runtime operation select, a selectable pipeline depth and an overflow flag. It sits between a sample source and a result consumer in the lab datapath.

Parameters:
DW, 32, input sample width (unsigned), 2..32
OW, 32, output width; result reduced modulo 2^OW
PIPE, 1, result latency in cycles after the completing sample edge; legal values 1 or 2

Ports:
clk  input  1  clock, rising edge
rst  input  1  asynchronous active-high reset
validi  input  1  data_in holds a valid sample this cycle
data_in  input  DW  unsigned sample
op_mode  input  2  operation select; sampled together with the completing (third) sample
valido  output  1  data_out/ovf valid
data_out  output  OW  result, truncated to OW bits
ovf  output  1  full-precision result not representable in OW unsigned bits; meaningful only when valido=1

Behaviour:
- Reset (rst=1, asynchronous):
  - valido=0, data_out=0, ovf=0.
  - Run counter, sample history (a,b) and all pipeline stages cleared to 0; in-flight results are discarded.
  - Outputs stay at reset values while rst=1, regardless of inputs.
- Run counter: 2-bit, saturating at 2.
  - Edge with validi=1: counter increments (saturates at 2); history shifts a<=b, b<=data_in.
  - Edge with validi=0: counter clears to 0; history is held but unusable.
- Window completion: an edge with validi=1 and counter==2 (third or later consecutive valid sample) launches one result from (a, b, c=data_in, op_mode).
- op_mode encoding (full-precision, 3*DW+2 bits, two's complement internally):
  - 00: a*b+c
  - 01: a*b-c
  - 10: a+b+c
  - 11: a*b*c
- ovf = 1 iff the full-precision result is <0 or >2^OW-1.
- data_out = full-precision result[OW-1:0].
- Latency:
  - PIPE=1: valido, data_out and ovf are updated at the launching edge and appear the cycle after the third sample.
  - PIPE=2: the multiply is registered, adding one further cycle; the pipeline is fully pipelined with no bubbles.
- Throughput: one result per cycle for as long as validi stays high. N consecutive valid samples produce N-2 results on N-2 consecutive cycles.
- Output hold: when no result retires in a cycle, valido=0. data_out and ovf hold their last value; the bench checks them only when valido=1.
- A validi gap of one or more cycles restarts the window; a run of 0, 1 or 2 valid samples never produces valido.
- op_mode changes mid-run affect only results launched after the change. Each result carries its own mode through the pipeline.
- Reset asserted mid-run (including with results in the PIPE=2 stage): no valido follows reset release until a fresh run of 3 samples.

Decomposition:
- Package win_mac_pkg:
  - op_mode_e enum (OP_MAC, OP_MSC, OP_ADD3, OP_MUL3)
  - localparam for full-precision width derivation
  - function range_ovf(full, OW)
- Sub-module win_mac_alu: computes the full-precision result and ovf from (a, b, c, op_mode), with an optional product register when PIPE=2.
- The top level owns the run counter, history registers, valid pipeline and output registers.

Test Plan:
1. rst=1 for 5 cycles with validi=1 and random data_in -> valido=0, data_out=0 throughout; no valido in the first 3 cycles after release.
2. DW=OW=32, PIPE=1, mode 00, validi for 3 cycles with data 2,3,4 -> one cycle after sample 4: valido=1, data_out=10, ovf=0; next cycle valido=0.
3. Mode 00, validi continuous for data 1,2,3,4,5 -> valido on 3 consecutive cycles, data_out 5, 10, 17; validi pattern 1,1,0,1,1,0,1 -> valido never asserted.
4. Mode 01 with data 2,3,10 -> data_out=0xFFFFFFFC, ovf=1.
   Mode 11 with data 0x10000,0x10000,2 -> data_out=0, ovf=1.
   Mode 10 with data 0xFFFFFFFF,1,0 -> data_out=0, ovf=1.
5. PIPE=2 repeat of scenario 3 -> identical values and gaps, each result one cycle later than with PIPE=1.
   op_mode toggled 00->10 on sample 4 of 1,2,3,4 -> outputs 5 then 9.
6. Reset mid-operation: PIPE=2, rst asserted asynchronously between clock edges while a result is in flight after samples 1,2,3,4 -> valido drops immediately and the result is lost; after release, samples 7,8 alone -> no valido.

Source files
------------

// File: rtl/win_mac_pkg.sv
// Shared types and helpers for the three-sample window MAC pipeline.
package win_mac_pkg;

    typedef enum logic [1:0] {
        OP_MAC  = 2'b00,
        OP_MSC  = 2'b01,
        OP_ADD3 = 2'b10,
        OP_MUL3 = 2'b11
    } op_mode_e;

    // Two guard bits above the 3*DW product keep a sign bit and the carry of a*b+c.
    localparam int GUARD_W = 2;
    localparam int MAX_DW  = 32;
    localparam int MAX_FW  = 3 * MAX_DW + GUARD_W;

    function automatic int full_w(input int dw);
        return 3 * dw + GUARD_W;
    endfunction

    // Anything negative or with bits at or above position ow cannot be shown in ow unsigned bits.
    function automatic logic range_ovf(input logic signed [MAX_FW-1:0] full, input int ow);
        logic signed [MAX_FW-1:0] hi;
        hi = full >>> ow;
        return (hi != '0);
    endfunction

endpackage

// File: rtl/win_mac_alu.sv
// Full-precision window arithmetic; PIPE=2 inserts a register after the multiplier.
module win_mac_alu
    import win_mac_pkg::*;
#(
    parameter int DW   = 32,
    parameter int OW   = 32,
    parameter int PIPE = 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          en_i,
    input  logic [DW-1:0] a_i,
    input  logic [DW-1:0] b_i,
    input  logic [DW-1:0] c_i,
    input  logic [1:0]    mode_i,
    output logic [OW-1:0] res_o,
    output logic          ovf_o
);

    localparam int FW = full_w(DW);

    logic signed [FW-1:0] a_x, b_x, c_x;
    logic signed [FW-1:0] ab_p0, sab_p0;
    logic signed [FW-1:0] ab_s, sab_s, c_s;
    op_mode_e             mode_s;
    logic signed [FW-1:0] full;

    assign a_x    = $signed({{(FW-DW){1'b0}}, a_i});
    assign b_x    = $signed({{(FW-DW){1'b0}}, b_i});
    assign c_x    = $signed({{(FW-DW){1'b0}}, c_i});
    assign ab_p0  = a_x * b_x;
    assign sab_p0 = a_x + b_x;

    generate
        if (PIPE == 2) begin : g_p2
            logic signed [FW-1:0] ab_p1_q, sab_p1_q, c_p1_q;
            op_mode_e             mode_p1_q;

            // ---- stage p0 -> p1: product, pair sum, current sample and mode
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    ab_p1_q   <= '0;
                    sab_p1_q  <= '0;
                    c_p1_q    <= '0;
                    mode_p1_q <= OP_MAC;
                end else if (en_i) begin
                    ab_p1_q   <= ab_p0;
                    sab_p1_q  <= sab_p0;
                    c_p1_q    <= c_x;
                    mode_p1_q <= op_mode_e'(mode_i);
                end
            end

            assign ab_s   = ab_p1_q;
            assign sab_s  = sab_p1_q;
            assign c_s    = c_p1_q;
            assign mode_s = mode_p1_q;
        end else begin : g_p1
            logic unused_ctl;
            assign unused_ctl = &{1'b0, clk, rst, en_i};
            assign ab_s   = ab_p0;
            assign sab_s  = sab_p0;
            assign c_s    = c_x;
            assign mode_s = op_mode_e'(mode_i);
        end
    endgenerate

    always_comb begin
        full = '0;
        case (mode_s)
            OP_MAC:  full = ab_s + c_s;
            OP_MSC:  full = ab_s - c_s;
            OP_ADD3: full = sab_s + c_s;
            OP_MUL3: full = ab_s * c_s;
            default: full = '0;
        endcase
    end

    assign res_o = full[OW-1:0];
    assign ovf_o = range_ovf(MAX_FW'(full), OW);

endmodule

// File: rtl/win_mac_pipe.sv
// Streaming 3-sample window evaluator: run counter, sample history, valid pipeline and output registers.
module win_mac_pipe
    import win_mac_pkg::*;
#(
    parameter int DW   = 32,
    parameter int OW   = 32,
    parameter int PIPE = 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          validi,
    input  logic [DW-1:0] data_in,
    input  logic [1:0]    op_mode,
    output logic          valido,
    output logic [OW-1:0] data_out,
    output logic          ovf
);

    logic [1:0]    cnt_q, cnt_d;
    logic [DW-1:0] a_q, b_q;
    logic          launch, retire;
    logic [OW-1:0] res;
    logic          res_ovf;
    logic          valido_q, ovf_q;
    logic [OW-1:0] data_q;

    // A result launches on the third and every later consecutive valid sample.
    assign launch = validi && (cnt_q == 2'd2);

    always_comb begin
        cnt_d = 2'd0;
        if (validi) cnt_d = (cnt_q == 2'd2) ? 2'd2 : cnt_q + 2'd1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= 2'd0;
            a_q   <= '0;
            b_q   <= '0;
        end else begin
            cnt_q <= cnt_d;
            if (validi) begin
                a_q <= b_q;
                b_q <= data_in;
            end
        end
    end

    win_mac_alu #(.DW(DW), .OW(OW), .PIPE(PIPE)) u_alu (
        .clk    (clk),
        .rst    (rst),
        .en_i   (launch),
        .a_i    (a_q),
        .b_i    (b_q),
        .c_i    (data_in),
        .mode_i (op_mode),
        .res_o  (res),
        .ovf_o  (res_ovf)
    );

    generate
        if (PIPE == 2) begin : g_vld_p2
            logic vld_p1_q;

            // ---- stage p0 -> p1: valid follows the registered product
            always_ff @(posedge clk or posedge rst) begin
                if (rst) vld_p1_q <= 1'b0;
                else     vld_p1_q <= launch;
            end

            assign retire = vld_p1_q;
        end else begin : g_vld_p1
            assign retire = launch;
        end
    endgenerate

    // ---- output stage: data and flag hold between results
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valido_q <= 1'b0;
            data_q   <= '0;
            ovf_q    <= 1'b0;
        end else begin
            valido_q <= retire;
            if (retire) begin
                data_q <= res;
                ovf_q  <= res_ovf;
            end
        end
    end

    assign valido   = valido_q;
    assign data_out = data_q;
    assign ovf      = ovf_q;

endmodule

// File: tb/tb_win_mac_pipe.sv
// Scoreboard bench driving a PIPE=1 and a PIPE=2 instance with the same directed sample stream.
module tb_win_mac_pipe;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        validi = 1'b0;
    logic [31:0] data_in = '0;
    logic [1:0]  op_mode = '0;
    logic        v1, o1, v2, o2;
    logic [31:0] d1, d2;

    int cyc = 0;
    int checks = 0;
    int errors = 0;

    typedef struct {
        int          cyc;
        logic [31:0] d;
        logic        o;
    } exp_t;

    exp_t q1[$];
    exp_t q2[$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    win_mac_pipe #(.DW(32), .OW(32), .PIPE(1)) u_p1 (
        .clk(clk), .rst(rst), .validi(validi), .data_in(data_in), .op_mode(op_mode),
        .valido(v1), .data_out(d1), .ovf(o1)
    );

    win_mac_pipe #(.DW(32), .OW(32), .PIPE(2)) u_p2 (
        .clk(clk), .rst(rst), .validi(validi), .data_in(data_in), .op_mode(op_mode),
        .valido(v2), .data_out(d2), .ovf(o2)
    );

    task automatic cmp(input string nm, input exp_t e, input logic [31:0] d, input logic o);
        checks += 3;
        if (e.cyc != cyc) begin
            errors++;
            $display("FAIL %s_cycle valido at cycle %0d, required cycle %0d", nm, cyc, e.cyc);
        end
        if (d !== e.d) begin
            errors++;
            $display("FAIL %s_data data_out %h, required %h (cycle %0d)", nm, d, e.d, cyc);
        end
        if (o !== e.o) begin
            errors++;
            $display("FAIL %s_ovf ovf %0b, required %0b (cycle %0d)", nm, o, e.o, cyc);
        end
    endtask

    always @(negedge clk) begin : mon1
        exp_t t;
        if (rst) begin
            checks++;
            if (v1 !== 1'b0 || d1 !== 32'd0 || o1 !== 1'b0) begin
                errors++;
                $display("FAIL p1_reset valido=%0b data_out=%h ovf=%0b, required 0 0 0", v1, d1, o1);
            end
        end else begin
            while (q1.size() > 0 && q1[0].cyc < cyc) begin
                checks++;
                errors++;
                t = q1.pop_front();
                $display("FAIL p1_missing no result %h at cycle %0d", t.d, t.cyc);
            end
            if (v1) begin
                if (q1.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL p1_unexpected valido=1 data_out=%h at cycle %0d, required no result", d1, cyc);
                end else begin
                    t = q1.pop_front();
                    cmp("p1", t, d1, o1);
                end
            end
        end
    end

    always @(negedge clk) begin : mon2
        exp_t t;
        if (rst) begin
            checks++;
            if (v2 !== 1'b0 || d2 !== 32'd0 || o2 !== 1'b0) begin
                errors++;
                $display("FAIL p2_reset valido=%0b data_out=%h ovf=%0b, required 0 0 0", v2, d2, o2);
            end
        end else begin
            while (q2.size() > 0 && q2[0].cyc < cyc) begin
                checks++;
                errors++;
                t = q2.pop_front();
                $display("FAIL p2_missing no result %h at cycle %0d", t.d, t.cyc);
            end
            if (v2) begin
                if (q2.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL p2_unexpected valido=1 data_out=%h at cycle %0d, required no result", d2, cyc);
                end else begin
                    t = q2.pop_front();
                    cmp("p2", t, d2, o2);
                end
            end
        end
    end

    task automatic smp(input logic [31:0] d, input logic [1:0] m);
        validi  = 1'b1;
        data_in = d;
        op_mode = m;
        @(posedge clk);
        #1;
    endtask

    // Sample that completes a window: PIPE=1 retires on the next cycle, PIPE=2 one later.
    task automatic smx(input logic [31:0] d, input logic [1:0] m, input logic [31:0] ed, input logic eo);
        q1.push_back('{cyc + 1, ed, eo});
        q2.push_back('{cyc + 2, ed, eo});
        smp(d, m);
    endtask

    task automatic idle(input int n);
        validi  = 1'b0;
        data_in = '0;
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        #2 rst = 1'b1;
        @(posedge clk);
        #1;
        repeat (5) smp($urandom, 2'($urandom));
        rst = 1'b0;
        smp($urandom, 2'b00);
        smp($urandom, 2'b00);
        idle(3);

        smp(32'd2, 2'b00);
        smp(32'd3, 2'b00);
        smx(32'd4, 2'b00, 32'd10, 1'b0);
        idle(3);

        smp(32'd1, 2'b00);
        smp(32'd2, 2'b00);
        smx(32'd3, 2'b00, 32'd5, 1'b0);
        smx(32'd4, 2'b00, 32'd10, 1'b0);
        smx(32'd5, 2'b00, 32'd17, 1'b0);
        idle(3);

        smp(32'd9, 2'b00);
        smp(32'd9, 2'b00);
        idle(1);
        smp(32'd9, 2'b00);
        smp(32'd9, 2'b00);
        idle(1);
        smp(32'd9, 2'b00);
        idle(3);

        smp(32'd2, 2'b01);
        smp(32'd3, 2'b01);
        smx(32'd10, 2'b01, 32'hFFFF_FFFC, 1'b1);
        idle(2);
        smp(32'd2, 2'b01);
        smp(32'd3, 2'b01);
        smx(32'd6, 2'b01, 32'd0, 1'b0);
        idle(2);
        smp(32'h0001_0000, 2'b11);
        smp(32'h0001_0000, 2'b11);
        smx(32'd2, 2'b11, 32'd0, 1'b1);
        idle(2);
        smp(32'd3, 2'b11);
        smp(32'd5, 2'b11);
        smx(32'd7, 2'b11, 32'd105, 1'b0);
        idle(2);
        smp(32'hFFFF_FFFF, 2'b10);
        smp(32'd1, 2'b10);
        smx(32'd0, 2'b10, 32'd0, 1'b1);
        idle(2);
        smp(32'hFFFF_FFFE, 2'b10);
        smp(32'd1, 2'b10);
        smx(32'd0, 2'b10, 32'hFFFF_FFFF, 1'b0);
        idle(3);

        smp(32'd1, 2'b00);
        smp(32'd2, 2'b00);
        smx(32'd3, 2'b00, 32'd5, 1'b0);
        smx(32'd4, 2'b10, 32'd9, 1'b0);
        idle(3);

        // Reset lands between edges with the second PIPE=2 result still in its product stage.
        smp(32'd1, 2'b00);
        smp(32'd2, 2'b00);
        q1.push_back('{cyc + 1, 32'd5, 1'b0});
        smp(32'd3, 2'b00);
        smp(32'd4, 2'b00);
        validi = 1'b0;
        #1 rst = 1'b1;
        idle(3);
        rst = 1'b0;
        smp(32'd7, 2'b00);
        smp(32'd8, 2'b00);
        idle(4);

        smp(32'd1, 2'b00);
        smp(32'd2, 2'b00);
        smx(32'd3, 2'b00, 32'd5, 1'b0);
        idle(4);

        checks++;
        if (q1.size() != 0) begin
            errors++;
            $display("FAIL p1_drain %0d results outstanding, required 0", q1.size());
        end
        checks++;
        if (q2.size() != 0) begin
            errors++;
            $display("FAIL p2_drain %0d results outstanding, required 0", q2.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
